// File: rtl/source_demux_pkg.sv
// rtl/source_demux_pkg.sv - source_demux states, framing constants and PLP lookup
// Guarded defaults mirror defines.v so the package also builds when that file is not compiled first.
`ifndef ADDR_PLP_FIRST
`define ADDR_PLP_FIRST 8'h20
`endif
`ifndef ADDR_PLP_LAST
`define ADDR_PLP_LAST 8'h23
`endif
`ifndef PKT_LEN_DEFAULT
`define PKT_LEN_DEFAULT 188
`endif
`ifndef HDR_LEN_DEFAULT
`define HDR_LEN_DEFAULT 4
`endif
`ifndef SYNC_BYTE_DEFAULT
`define SYNC_BYTE_DEFAULT 8'h47
`endif

package source_demux_pkg;
  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  localparam logic [7:0] ADDR_PLP_FIRST = `ADDR_PLP_FIRST;
  localparam logic [7:0] ADDR_PLP_LAST  = `ADDR_PLP_LAST;
  localparam int         PKT_LEN_DEF    = `PKT_LEN_DEFAULT;
  localparam int         HDR_LEN_DEF    = `HDR_LEN_DEFAULT;
  localparam logic [7:0] SYNC_BYTE_DEF  = `SYNC_BYTE_DEFAULT;

  // Returns {hit, index}; the lowest matching table entry wins.
  function automatic logic [2:0] plp_lookup(input logic [7:0] id, input logic [3:0][7:0] tbl);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (tbl[i] == id) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction
endpackage

// File: rtl/defines.v
// rtl/defines.v - shared mux/demux framing defaults and SPI register addresses
`ifndef ADDR_PLP_FIRST
`define ADDR_PLP_FIRST 8'h20
`endif
`ifndef ADDR_PLP_LAST
`define ADDR_PLP_LAST 8'h23
`endif
`ifndef PKT_LEN_DEFAULT
`define PKT_LEN_DEFAULT 188
`endif
`ifndef HDR_LEN_DEFAULT
`define HDR_LEN_DEFAULT 4
`endif
`ifndef SYNC_BYTE_DEFAULT
`define SYNC_BYTE_DEFAULT 8'h47
`endif

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             SYS_CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/source_demux.sv
// rtl/source_demux.sv - header+TS packet demultiplexer routing packets to 4 FIFO write ports
// Optional strict header checking of bytes 1..3: HEADER_STRICT_EN.
module source_demux
  import source_demux_pkg::*;
#(
  parameter int         PKT_LEN   = PKT_LEN_DEF,
  parameter int         HDR_LEN   = HDR_LEN_DEF,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         CNT_W     = 16
) (
  input  logic             SYS_CLK,
  input  logic             RST,
  input  logic [7:0]       DATA_IN,
  input  logic             D_VALID_IN,
  input  logic             P_SYNC_IN,
  input  logic [3:0]       SPACE_OK,
  input  logic [7:0]       SPI_ADDRESS,
  input  logic [7:0]       SPI_DATA,
  input  logic             RISING_SS,
  output logic [7:0]       DATA_OUT,
  output logic [3:0]       WR_REQ,
  output logic [3:0]       PKT_DONE,
  output logic [3:0]       PKT_ABORT,
  output logic [CNT_W-1:0] ERR_HDR_CNT,
  output logic [CNT_W-1:0] ERR_SYNC_CNT,
  output logic [CNT_W-1:0] ERR_OVF_CNT
);
  localparam logic [7:0] PKT_LAST = 8'(PKT_LEN - 1);
  localparam logic [7:0] HDR_LAST = 8'(HDR_LEN - 1);

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [1:0]      ch_q, ch_d;
  logic            miss_q, miss_d;
  logic [3:0][7:0] tbl_q, tbl_d;
  logic [7:0]      data_out_q, data_out_d;
  logic [3:0]      wr_req_q, wr_req_d;
  logic [3:0]      done_q, done_d;
  logic [3:0]      abort_q, abort_d;
  logic            hdr_inc, sync_inc, ovf_inc;
  logic [2:0]      lookup;
  logic            hdr_bad;
`ifdef HEADER_STRICT_EN
  logic            strict_err_q, strict_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    miss_d     = miss_q;
    tbl_d      = tbl_q;
    data_out_d = data_out_q;
    wr_req_d   = '0;
    done_d     = '0;
    abort_d    = '0;
    hdr_inc    = 1'b0;
    sync_inc   = 1'b0;
    ovf_inc    = 1'b0;
    hdr_bad    = 1'b0;
    lookup     = plp_lookup(DATA_IN, tbl_q);
`ifdef HEADER_STRICT_EN
    strict_err_d = strict_err_q;
`endif

    // The header compare below reads tbl_q, so a same-cycle write only lands afterwards.
    if (RISING_SS && (SPI_ADDRESS >= ADDR_PLP_FIRST) && (SPI_ADDRESS <= ADDR_PLP_LAST))
      tbl_d[2'(SPI_ADDRESS - ADDR_PLP_FIRST)] = SPI_DATA;

    if (D_VALID_IN) begin
      case (state_q)
        ST_HEADER: begin
          if (P_SYNC_IN) begin
            sync_inc = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'd0) begin
              ch_d   = lookup[2] ? lookup[1:0] : 2'd0;
              miss_d = !lookup[2];
`ifdef HEADER_STRICT_EN
              strict_err_d = 1'b0;
            end else if (cnt_q == 8'd1) begin
              if (DATA_IN != ({6'd0, ch_q} + 8'd2)) strict_err_d = 1'b1;
            end else begin
              if (DATA_IN != 8'h00) strict_err_d = 1'b1;
`endif
            end
            if (cnt_q == HDR_LAST) begin
              cnt_d   = '0;
              hdr_bad = miss_d;
`ifdef HEADER_STRICT_EN
              hdr_bad = miss_d || strict_err_d;
`endif
              if (hdr_bad) begin
                hdr_inc = 1'b1;
                state_d = ST_DROP;
              end else if (!SPACE_OK[ch_d]) begin
                ovf_inc = 1'b1;
                state_d = ST_DROP;
              end else begin
                state_d = ST_PAYLOAD;
              end
            end
          end
        end
        ST_PAYLOAD: begin
          if (cnt_q == 8'd0 && !(P_SYNC_IN && DATA_IN == SYNC_BYTE)) begin
            sync_inc = 1'b1;
            state_d  = ST_HEADER;
          end else if (cnt_q != 8'd0 && P_SYNC_IN) begin
            sync_inc = 1'b1;
            abort_d  = 4'b0001 << ch_q;
            cnt_d    = '0;
            state_d  = ST_HEADER;
          end else begin
            data_out_d = DATA_IN;
            wr_req_d   = 4'b0001 << ch_q;
            if (cnt_q == PKT_LAST) begin
              done_d  = 4'b0001 << ch_q;
              cnt_d   = '0;
              state_d = ST_HEADER;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        ST_DROP: begin
          if ((cnt_q != 8'd0 && P_SYNC_IN) || cnt_q == PKT_LAST) begin
            cnt_d   = '0;
            state_d = ST_HEADER;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_HEADER;
        end
      endcase
    end
  end

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_HEADER;
      cnt_q      <= '0;
      ch_q       <= '0;
      miss_q     <= 1'b0;
      tbl_q      <= {8'd3, 8'd2, 8'd1, 8'd0};
      data_out_q <= '0;
      wr_req_q   <= '0;
      done_q     <= '0;
      abort_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      miss_q     <= miss_d;
      tbl_q      <= tbl_d;
      data_out_q <= data_out_d;
      wr_req_q   <= wr_req_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

`ifdef HEADER_STRICT_EN
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) strict_err_q <= 1'b0;
    else      strict_err_q <= strict_err_d;
  end
`endif

  sat_counter #(.WIDTH(CNT_W)) u_hdr_cnt (.SYS_CLK(SYS_CLK), .RST(RST), .inc(hdr_inc), .count(ERR_HDR_CNT));
  sat_counter #(.WIDTH(CNT_W)) u_sync_cnt (.SYS_CLK(SYS_CLK), .RST(RST), .inc(sync_inc), .count(ERR_SYNC_CNT));
  sat_counter #(.WIDTH(CNT_W)) u_ovf_cnt (.SYS_CLK(SYS_CLK), .RST(RST), .inc(ovf_inc), .count(ERR_OVF_CNT));

  assign DATA_OUT  = data_out_q;
  assign WR_REQ    = wr_req_q;
  assign PKT_DONE  = done_q;
  assign PKT_ABORT = abort_q;
endmodule

// File: tb/tb_source_demux.sv
// tb/tb_source_demux.sv - scoreboard bench for source_demux
module tb_source_demux;
  import source_demux_pkg::*;

  localparam int PLEN = 188;
  localparam logic [7:0] SYNC = 8'h47;

  logic        SYS_CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  DATA_IN = '0;
  logic        D_VALID_IN = 1'b0;
  logic        P_SYNC_IN = 1'b0;
  logic [3:0]  SPACE_OK = 4'hF;
  logic [7:0]  SPI_ADDRESS = '0;
  logic [7:0]  SPI_DATA = '0;
  logic        RISING_SS = 1'b0;
  logic [7:0]  DATA_OUT;
  logic [3:0]  WR_REQ, PKT_DONE, PKT_ABORT;
  logic [15:0] ERR_HDR_CNT, ERR_SYNC_CNT, ERR_OVF_CNT;

  source_demux dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .DATA_IN(DATA_IN), .D_VALID_IN(D_VALID_IN),
    .P_SYNC_IN(P_SYNC_IN), .SPACE_OK(SPACE_OK), .SPI_ADDRESS(SPI_ADDRESS),
    .SPI_DATA(SPI_DATA), .RISING_SS(RISING_SS), .DATA_OUT(DATA_OUT), .WR_REQ(WR_REQ),
    .PKT_DONE(PKT_DONE), .PKT_ABORT(PKT_ABORT), .ERR_HDR_CNT(ERR_HDR_CNT),
    .ERR_SYNC_CNT(ERR_SYNC_CNT), .ERR_OVF_CNT(ERR_OVF_CNT)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   wr_cnt[4] = '{0, 0, 0, 0};
  int   abort_cnt[4] = '{0, 0, 0, 0};
  logic v_prev = 1'b0;

  always @(posedge SYS_CLK) v_prev <= D_VALID_IN;

  always @(negedge SYS_CLK) begin
    if (RST) begin
      exp_t e;
      for (int c = 0; c < 4; c++) if (PKT_ABORT[c]) abort_cnt[c]++;
      if (!v_prev) begin
        tests++;
        assert ({WR_REQ, PKT_DONE, PKT_ABORT} === 12'h000) else begin
          fails++;
          $error("FAIL idle_outputs: got %03h expected 000", {WR_REQ, PKT_DONE, PKT_ABORT});
        end
      end
      if (WR_REQ !== 4'h0) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $error("FAIL stray_write: got WR_REQ=%b expected no write", WR_REQ);
        end else begin
          e = sb.pop_front();
          for (int c = 0; c < 4; c++) if (WR_REQ[c]) wr_cnt[c]++;
          assert ({WR_REQ, DATA_OUT, PKT_DONE} === {4'b0001 << e.ch, e.data, e.done ? 4'b0001 << e.ch : 4'b0000})
          else begin
            fails++;
            $error("FAIL write: got wr=%b data=%02h done=%b expected ch=%0d data=%02h done=%b",
                   WR_REQ, DATA_OUT, PKT_DONE, e.ch, e.data, e.done);
          end
        end
      end else if (PKT_DONE !== 4'h0) begin
        tests++;
        fails++;
        $error("FAIL done_no_write: got PKT_DONE=%b expected 0000", PKT_DONE);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic vbyte(input logic [7:0] d, input logic ps, input bit gaps);
    DATA_IN = d; P_SYNC_IN = ps; D_VALID_IN = 1'b1;
    @(posedge SYS_CLK); #1;
    D_VALID_IN = 1'b0; P_SYNC_IN = 1'b0; DATA_IN = 8'hEE;
    if (gaps) begin
      @(posedge SYS_CLK); #1;
    end
  endtask

  task automatic hdr(input logic [7:0] plp, input logic [7:0] b1, input bit gaps);
    vbyte(plp, 1'b0, gaps);
    vbyte(b1, 1'b0, gaps);
    vbyte(8'h00, 1'b0, gaps);
    vbyte(8'h00, 1'b0, gaps);
  endtask

  // Sends payload indices 0..n-1; index trunc_at is sent as a P_SYNC byte and ends the packet.
  task automatic pay(input int ch, input int n, input int trunc_at, input bit wr, input bit gaps);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      if (i == trunc_at) begin
        vbyte(8'hA5, 1'b1, gaps);
        return;
      end
      d = (i == 0) ? SYNC : 8'(i * 13 + ch * 5 + 1);
      if (wr) sb.push_back('{2'(ch), d, i == PLEN - 1});
      vbyte(d, i == 0, gaps);
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge SYS_CLK);
    #1;
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic counters(input string tag, input int h, input int s, input int o);
    chk({tag, "_hdr"}, ERR_HDR_CNT, h);
    chk({tag, "_sync"}, ERR_SYNC_CNT, s);
    chk({tag, "_ovf"}, ERR_OVF_CNT, o);
  endtask

  initial begin
    int w0;
    #3;
    chk("rst_outputs", {DATA_OUT, WR_REQ, PKT_DONE, PKT_ABORT}, 0);
    counters("rst", 0, 0, 0);
    @(negedge SYS_CLK); RST = 1'b1;
    @(posedge SYS_CLK); #1;

    // Default table routes PLP 2 to channel 2, back-to-back and then with gaps.
    hdr(8'h02, 8'h04, 0); pay(2, PLEN, -1, 1, 0); settle();
    chk("t1_wr2", wr_cnt[2], PLEN);
    counters("t1", 0, 0, 0);
    hdr(8'h02, 8'h04, 1); pay(2, PLEN, -1, 1, 1); settle();
    chk("t2_wr2", wr_cnt[2], 2 * PLEN);

    // Reprogram entry 1, then an unknown PLP is dropped.
    SPI_ADDRESS = ADDR_PLP_FIRST + 8'd1; SPI_DATA = 8'h55; RISING_SS = 1'b1;
    @(posedge SYS_CLK); #1; RISING_SS = 1'b0;
    hdr(8'h55, 8'h03, 0); pay(1, PLEN, -1, 1, 0); settle();
    chk("t3_wr1", wr_cnt[1], PLEN);
    hdr(8'h01, 8'h03, 0); pay(1, PLEN, -1, 0, 0); settle();
    counters("t3", 1, 0, 0);
    hdr(8'h03, 8'h05, 0); pay(3, PLEN, -1, 1, 0); settle();

    // No FIFO space on channel 0 drops the packet.
    SPACE_OK = 4'b1110;
    hdr(8'h00, 8'h02, 0); pay(0, PLEN, -1, 0, 0); settle();
    counters("t4", 1, 0, 1);
    chk("t4_wr0", wr_cnt[0], 0);
    SPACE_OK = 4'b1111;
    hdr(8'h00, 8'h02, 0); pay(0, PLEN, -1, 1, 0); settle();
    chk("t4_wr0b", wr_cnt[0], PLEN);

    // Truncated packet, bad sync byte, P_SYNC inside a header.
    w0 = wr_cnt[3];
    hdr(8'h03, 8'h05, 0); pay(3, PLEN, 100, 1, 0); settle();
    chk("t5_wr3", wr_cnt[3] - w0, 100);
    chk("t5_abort3", abort_cnt[3], 1);
    chk("t5_abort_other", abort_cnt[0] + abort_cnt[1] + abort_cnt[2], 0);
    counters("t5", 1, 1, 1);
    hdr(8'h02, 8'h04, 0); pay(2, PLEN, -1, 1, 0); settle();
    hdr(8'h02, 8'h04, 0); vbyte(8'h46, 1'b1, 0); settle();
    counters("t5b", 1, 2, 1);
    vbyte(8'h02, 1'b1, 0);
    hdr(8'h00, 8'h02, 0); pay(0, PLEN, -1, 1, 0); settle();
    counters("t5c", 1, 3, 1);

    // Asynchronous reset in the middle of a payload.
    hdr(8'h02, 8'h04, 0); pay(2, 50, -1, 1, 0);
    @(negedge SYS_CLK); #1; RST = 1'b0; #1;
    chk("t6_outputs", {DATA_OUT, WR_REQ, PKT_DONE, PKT_ABORT}, 0);
    counters("t6", 0, 0, 0);
    @(negedge SYS_CLK); RST = 1'b1;
    @(posedge SYS_CLK); #1;
    chk("t6_sb", sb.size(), 0);
    hdr(8'h55, 8'h03, 0); pay(1, PLEN, -1, 0, 0); settle();
    counters("t6b", 1, 0, 0);
    w0 = wr_cnt[1];
    hdr(8'h01, 8'h03, 0); pay(1, PLEN, -1, 1, 0); settle();
    chk("t6_wr1", wr_cnt[1] - w0, PLEN);

`ifdef HEADER_STRICT_EN
    hdr(8'h00, 8'h05, 0); pay(0, PLEN, -1, 0, 0); settle();
    counters("t7", 2, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
